// File: rtl/button_event_ctrl.sv
// button_event_ctrl: multi-channel input debounce and event scheduler.
// Shared sample tick, per-channel debounce, round-robin into an event FIFO.
module button_event_ctrl #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 4,
    parameter int STABLE_TICKS = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CH_W         = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] en_mask,
    output logic [N_CH-1:0] state_out,
    output logic            sample_tick,
    output logic            evt_valid,
    output logic [CH_W:0]   evt_data,
    input  logic            evt_ack,
    output logic            overflow,
    input  logic            overflow_clr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_TICKS - 1);
    localparam logic [CH_W-1:0] CH_MAX  = CH_W'(N_CH - 1);

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   cnt [N_CH];
    logic [N_CH-1:0] st;
    logic [N_CH-1:0] qual;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] dir;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] gnt_oh;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] gnt;
    logic            gnt_vld;
    logic [CH_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            lost;

    // two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // shared prescaler producing the sample strobe
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
        end else if (presc == PRE_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign sample_tick = (presc == PRE_MAX);

    // a channel qualifies on the tick that completes its stable run
    always_comb begin
        qual = '0;
        for (int i = 0; i < N_CH; i++) begin
            qual[i] = sample_tick && (sync2[i] != st[i])
                      && (cnt[i] == CNT_MAX);
        end
    end

    // debounce counters and accepted levels, ticking only on the strobe
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            st <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (sample_tick) begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    st[i]  <= sync2[i];
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign state_out = st;

    assign full  = (wptr[AW] != rptr[AW])
                   && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign req   = pend & en_mask;

    // round-robin grant, searching upward from rr_ptr with wrap
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        gnt_oh  = '0;
        idx     = '0;
        if (!full) begin
            for (int k = 0; k < N_CH; k++) begin
                idx = CH_W'((int'(rr_ptr) + k) % N_CH);
                if (!gnt_vld && req[idx]) begin
                    gnt_vld     = 1'b1;
                    gnt         = idx;
                    gnt_oh[idx] = 1'b1;
                end
            end
        end
    end

    assign push = gnt_vld;
    assign pop  = evt_ack && !empty;

    // a new edge on a still-pending channel, unless that old event is
    // leaving for the FIFO in this same cycle, loses the older event
    assign lost = |(qual & en_mask & pend & ~gnt_oh);

    // pending events, their direction, overflow and the rr pointer
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pend     <= '0;
            dir      <= '0;
            overflow <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!en_mask[i]) begin
                    pend[i] <= 1'b0;
                end else if (qual[i]) begin
                    pend[i] <= 1'b1;
                    dir[i]  <= sync2[i];
                end else if (gnt_oh[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (lost) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (push) begin
                rr_ptr <= (gnt == CH_MAX) ? '0 : gnt + 1'b1;
            end
        end
    end

    // show-ahead event FIFO with wrap-bit pointers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= {dir[gnt], gnt};
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign evt_valid = !empty;
    assign evt_data  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed bench for button_event_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] raw_in = 4'h0;
    logic [3:0] en_mask = 4'hF;
    logic       evt_ack = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [3:0] state_out;
    logic       sample_tick;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic       overflow;

    int n_run  = 0;
    int n_fail = 0;
    int bad;

    button_event_ctrl dut (
        .clk          (clk),
        .Reset        (Reset),
        .raw_in       (raw_in),
        .en_mask      (en_mask),
        .state_out    (state_out),
        .sample_tick  (sample_tick),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_ack      (evt_ack),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_st(input int ch, input logic v, input int maxc,
                           input string tag);
        int n;
        n = 0;
        while (state_out[ch] !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state_out[ch]), 32'(v));
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int n;
        n = 0;
        while (evt_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(evt_valid), 32'd1);
    endtask

    task automatic pop_chk(input string tag, input logic [2:0] exp);
        check({tag, "_v"}, 32'(evt_valid), 32'd1);
        check(tag, 32'(evt_data), 32'(exp));
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
    endtask

    task automatic rst_pulse();
        raw_in = 4'h0;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_st"}, 32'(state_out), 32'd0);
        check({tag, "_tick"}, 32'(sample_tick), 32'd0);
        check({tag, "_v"}, 32'(evt_valid), 32'd0);
        check({tag, "_d"}, 32'(evt_data), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("tick_%0d", k), 32'(sample_tick),
                  32'(k == 3));
        end

        // bounce: 9-cycle levels never span four ticks
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            raw_in[0] = ~raw_in[0];
            repeat (9) begin
                @(negedge clk);
                if (state_out[0] | evt_valid | overflow) bad++;
            end
        end
        repeat (30) begin
            @(negedge clk);
            if (state_out[0] | evt_valid | overflow) bad++;
        end
        check("bounce_quiet", 32'(bad), 32'd0);

        // clean rise and fall on ch1
        raw_in[1] = 1'b1;
        wait_st(1, 1'b1, 22, "s2_rise_st");
        wait_valid(4, "s2_rise_v");
        check("s2_rise_d", 32'(evt_data), 32'b101);
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
        check("s2_ack_empty", 32'(evt_valid), 32'd0);
        repeat (20) @(negedge clk);
        raw_in[1] = 1'b0;
        wait_st(1, 1'b0, 30, "s2_fall_st");
        wait_valid(4, "s2_fall_v");
        pop_chk("s2_fall", 3'b001);

        // round robin from rr_ptr=0, popped in consecutive cycles
        rst_pulse();
        raw_in = 4'b1101;
        wait_st(3, 1'b1, 30, "s3_st");
        wait_valid(4, "s3_v");
        pop_chk("s3_ch0", 3'b100);
        pop_chk("s3_ch2", 3'b110);
        pop_chk("s3_ch3", 3'b111);
        check("s3_empty", 32'(evt_valid), 32'd0);
        raw_in = 4'b0100;
        wait_st(0, 1'b0, 30, "s3_fall_st");
        wait_valid(4, "s3_fall_v");
        pop_chk("s3_f0", 3'b000);
        pop_chk("s3_f3", 3'b011);
        raw_in = 4'b1101;
        wait_st(0, 1'b1, 30, "s3_wrap_st");
        wait_valid(4, "s3_wrap_v");
        pop_chk("s3_w0", 3'b100);
        pop_chk("s3_w3", 3'b111);

        // full FIFO, waiting pends and overflow (rr_ptr brought to 1)
        rst_pulse();
        raw_in = 4'b0001;
        wait_st(0, 1'b1, 30, "s4_prep_st");
        wait_valid(4, "s4_prep_v");
        pop_chk("s4_prep_r", 3'b100);
        raw_in = 4'b0000;
        wait_st(0, 1'b0, 30, "s4_prep_st2");
        wait_valid(4, "s4_prep_v2");
        pop_chk("s4_prep_f", 3'b000);
        raw_in = 4'hF;
        wait_st(0, 1'b1, 30, "s4_all_st");
        repeat (6) @(negedge clk);
        check("s4_head", 32'(evt_data), 32'b101);
        raw_in = 4'b1100;
        wait_st(1, 1'b0, 30, "s4_fall_st");
        repeat (2) @(negedge clk);
        check("s4_no_ovf", 32'(overflow), 32'd0);
        check("s4_head2", 32'(evt_data), 32'b101);
        raw_in = 4'b1101;
        wait_st(0, 1'b1, 30, "s4_rise0_st");
        check("s4_ovf_set", 32'(overflow), 32'd1);
        pop_chk("s4_pop1", 3'b101);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("s4_ovf_clr", 32'(overflow), 32'd0);
        raw_in = 4'b1100;
        overflow_clr = 1'b1;
        wait_st(0, 1'b0, 30, "s4_fall0_st");
        overflow_clr = 1'b0;
        check("s4_ovf_setwins", 32'(overflow), 32'd1);
        pop_chk("s4_d2", 3'b110);
        pop_chk("s4_d3", 3'b111);
        pop_chk("s4_d0", 3'b100);
        pop_chk("s4_d1f", 3'b001);
        wait_valid(4, "s4_last_v");
        pop_chk("s4_d0f", 3'b000);
        check("s4_empty", 32'(evt_valid), 32'd0);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;

        // masked channel debounces but raises no events
        rst_pulse();
        en_mask = 4'b0111;
        raw_in = 4'b1000;
        wait_st(3, 1'b1, 30, "s5_rise_st");
        repeat (4) @(negedge clk);
        check("s5_no_evt_r", 32'(evt_valid), 32'd0);
        raw_in = 4'b0000;
        wait_st(3, 1'b0, 30, "s5_fall_st");
        repeat (4) @(negedge clk);
        check("s5_no_evt_f", 32'(evt_valid), 32'd0);
        en_mask = 4'hF;
        repeat (4) @(negedge clk);
        check("s5_unmask", 32'(evt_valid), 32'd0);
        check("s5_ovf", 32'(overflow), 32'd0);

        // reset in the middle of a qualification
        raw_in = 4'b0100;
        repeat (10) @(negedge clk);
        Reset = 1'b1;
        #1;
        chk_zero("s6_rst_now");
        repeat (3) @(negedge clk);
        chk_zero("s6_rst_hold");
        Reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 15) check("s6_st15", 32'(state_out[2]), 32'd0);
            if (k == 16) begin
                check("s6_st16", 32'(state_out[2]), 32'd1);
                check("s6_v16", 32'(evt_valid), 32'd0);
            end
            if (k == 17) begin
                check("s6_v17", 32'(evt_valid), 32'd1);
                check("s6_d17", 32'(evt_data), 32'b110);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
